div: RTL and testbench

Iterative 32-bit integer divider for the EX stage; it implements DIV and DIVU. EX decodes the instruction, raises `start_i` with the operands, and stalls the pipeline until `ready_o` is asserted. It then takes `result_o` as the {HI, LO} pair and forwards it on the hi/lo write path with `enhilo_o` asserted. The unit uses a 32-iteration restoring algorithm with a 4-state FSM and supports abort.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div.sv | 120 ++++++++++++
 tb/tb_div.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
// Holds the FSM state encoding, bus widths and an operand-magnitude helper.
package div_pkg;

    localparam int REG_W    = 32;
    localparam int DREG_W   = 64;
    localparam int CNT_W    = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = 6'd32;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [REG_W-1:0] magnitude(input logic is_signed,
                                                   input logic [REG_W-1:0] op);
        return (is_signed && op[REG_W-1]) ? (~op + 1'b1) : op;
    endfunction

endpackage

// File: rtl/div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// a sign-correction edge at the end, and abort via annul or a dropped start.
module div
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [REG_W-1:0]    opdata1_i,
    input  logic [REG_W-1:0]    opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [DREG_W-1:0]   result_o,
    output logic                ready_o
);

    div_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DREG_W:0]    dividend, dividend_n;
    logic [REG_W-1:0]   divisor, divisor_n;
    logic               neg_quot, neg_quot_n;
    logic               neg_rem, neg_rem_n;
    logic [DREG_W-1:0]  result_n;
    logic               ready_n;
    logic [REG_W:0]     diff;
    logic [REG_W-1:0]   quot, rem;

    assign diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
    assign quot = dividend[31:0];
    assign rem  = dividend[64:33];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        neg_quot_n = neg_quot;
        neg_rem_n  = neg_rem;
        result_n   = result_o;
        ready_n    = ready_o;

        case (state)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = DIV_BY_ZERO;
                    end else begin
                        state_n    = DIV_ON;
                        cnt_n      = '0;
                        divisor_n  = magnitude(signed_div_i, opdata2_i);
                        dividend_n = {32'b0, magnitude(signed_div_i, opdata1_i), 1'b0};
                        neg_quot_n = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_n  = signed_div_i && opdata1_i[31];
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                end else begin
                    state_n  = DIV_END;
                    result_n = '0;
                    ready_n  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                end else if (cnt != LAST_ITER) begin
                    // A negative trial difference means the divisor did not fit: shift in 0.
                    if (diff[REG_W])
                        dividend_n = {dividend[63:0], 1'b0};
                    else
                        dividend_n = {diff[31:0], dividend[31:0], 1'b1};
                    cnt_n = cnt + 1'b1;
                end else begin
                    result_n = {neg_rem  ? (~rem  + 1'b1) : rem,
                                neg_quot ? (~quot + 1'b1) : quot};
                    ready_n  = DIV_RESULT_READY;
                    state_n  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_n = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            neg_quot <= neg_quot_n;
            neg_rem  <= neg_rem_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized
// DIV/DIVU operations checked against a plain-arithmetic reference model.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int tests = 0;
    int fails = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient}, truncating division, zero divisor gives 0.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'h0;
        if (!sg) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Full transaction: start, latency, result, hold, release.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] exp;
        exp = model(sg, a, b);
        @(negedge clk);
        signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sg;
        n = 0;
        while (!ready_o && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_lat"}, 64'(n), (b == 0) ? 64'd1 : 64'd33);
        check({tag, "_res"}, result_o, exp);
        @(posedge clk); #1;
        check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rel"}, {ready_o, result_o}, 65'h0);
    endtask

    initial begin
        #12;
        check("reset", {ready_o, result_o}, 65'h0);
        @(negedge clk); rst = 1'b1;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        check("divu_100_7_val", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div("div_zero", 1'b1, 32'd1234, 32'd0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // Abort at E+10: no result may ever appear.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk); annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_now", {ready_o, result_o}, 65'h0);
        @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready_o) seen = 1'b1;
            end
            check("annul_never_ready", 64'(seen), 64'd0);
        end
        do_div("divu_50_5", 1'b0, 32'd50, 32'd5);

        // Reset mid-iteration, between clock edges.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (12) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("rst_mid_on", {ready_o, result_o}, 65'h0);
        @(negedge clk); start_i = 1'b0; rst = 1'b1;
        do_div("divu_1_1", 1'b0, 32'd1, 32'd1);

        // Reset while a nonzero result is being held.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (36) @(posedge clk);
        #1 check("pre_rst_hold", {ready_o, result_o}, {1'b1, model(1'b0, 32'd1000, 32'd7)});
        #2 rst = 1'b0;
        #1 check("rst_in_end", {ready_o, result_o}, 65'h0);
        @(negedge clk); start_i = 1'b0; rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic sg;
            logic [31:0] a, b;
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = b >> $urandom_range(8, 31);
                1: b = 32'($urandom_range(0, 3));
                2: a = {1'b1, a[30:0]};
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
                default: ;
            endcase
            do_div($sformatf("rnd%0d", i), sg, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
